// File: rtl/barrier_arbiter_estacionamiento.sv
// rtl/barrier_arbiter_estacionamiento.sv - shared car-park barrier arbiter; optional macro EXIT_PRIORITY_EN
module barrier_arbiter_estacionamiento #(
  parameter int CAPACITY     = 7,
  parameter int OPEN_CYCLES  = 8,
  parameter int GUARD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_in,
  input  logic       req_out,
  input  logic [2:0] cantidad,
  input  logic       pass_done,
  output logic       gate_open,
  output logic       dir_out,
  output logic       full,
  output logic       denied_in
);

  localparam int TW = $clog2(OPEN_CYCLES + 1);
  localparam int GW = $clog2(GUARD_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(OPEN_CYCLES - 1);
  localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OPEN_IN  = 2'd1,
    OPEN_OUT = 2'd2,
    GUARD    = 2'd3
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [GW-1:0] guard;
  logic          req_in_q;
  logic          ent_ok;
  logic          sal_ok;
  logic          grant_out;

  // Entry is only eligible with room left; exit only with at least one car inside.
  assign ent_ok = req_in & ~full;
  assign sal_ok = req_out & (cantidad != 3'd0);

`ifdef EXIT_PRIORITY_EN
  // Exit wins every tie; no fairness history is kept.
  assign grant_out = sal_ok;
`else
  logic last_served;
  // On a tie, serve the side that was not served last time.
  assign grant_out = sal_ok & (~ent_ok | ~last_served);
`endif

  // Refusal pulses only on the rising edge of the entry request.
  assign denied_in = req_in & ~req_in_q & full;

  // Occupancy flag and request history, independent of the gate state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full     <= 1'b0;
      req_in_q <= 1'b0;
    end else begin
      full     <= ({29'd0, cantidad} >= 32'(CAPACITY));
      req_in_q <= req_in;
    end
  end

  // Gate FSM with registered gate_open/dir_out and saturating open/guard timers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      timer     <= '0;
      guard     <= '0;
      gate_open <= 1'b0;
      dir_out   <= 1'b0;
`ifndef EXIT_PRIORITY_EN
      last_served <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (ent_ok || sal_ok) begin
            state     <= grant_out ? OPEN_OUT : OPEN_IN;
            timer     <= TIMER_LOAD;
            gate_open <= 1'b1;
            dir_out   <= grant_out;
`ifndef EXIT_PRIORITY_EN
            last_served <= grant_out;
`endif
          end
        end
        OPEN_IN, OPEN_OUT: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end
          if (pass_done || (timer == '0)) begin
            state     <= GUARD;
            gate_open <= 1'b0;
            guard     <= GUARD_LOAD;
          end
        end
        GUARD: begin
          if (guard != '0) begin
            guard <= guard - 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          gate_open <= 1'b0;
        end
      endcase
    end
  end

endmodule
